// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with early exit on the first differing bit.
// Start/done handshake; gt/eq/lt are registered and held until the next accepted start.
module serial_magnitude_comparator #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] op_a, op_b;
  logic             bit_a, bit_b, sign_pos, a_wins;

  assign bit_a    = op_a[idx];
  assign bit_b    = op_b[idx];
  assign sign_pos = SIGNED && (idx == IW'(WIDTH - 1));
  // On a differing bit, A is larger when its bit is 1 -- inverted at the sign position.
  assign a_wins   = bit_a ^ sign_pos;

  assign busy = (state == S_CMP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            idx   <= IW'(WIDTH - 1);
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (bit_a != bit_b) begin
            gt    <= a_wins;
            lt    <= ~a_wins;
            state <= S_DONE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for the serial comparator: three instances (8-bit unsigned, 8-bit signed, 4-bit unsigned)
// driven from a vector table, hand-written corner sequences and random operands against a model.
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0] st;
  logic [7:0] a0, b0, a1, b1;
  logic [3:0] a2, b2;
  logic [2:0] busy, done, gt, eq, lt;

  serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .reset(reset), .start(st[0]), .a(a0), .b(b0),
    .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]));
  serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .reset(reset), .start(st[1]), .a(a1), .b(b1),
    .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]));
  serial_magnitude_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (
    .clk(clk), .reset(reset), .start(st[2]), .a(a2), .b(b2),
    .busy(busy[2]), .done(done[2]), .gt(gt[2]), .eq(eq[2]), .lt(lt[2]));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;   // {gt,eq,lt}
    int         lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int wid(input int w);
    return (w == 2) ? 4 : 8;
  endfunction

  function automatic logic [2:0] res(input int w);
    return {gt[w], eq[w], lt[w]};
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
    st[w] = s;
    case (w)
      0:       begin a0 = av; b0 = bv; end
      1:       begin a1 = av; b1 = bv; end
      default: begin a2 = av[3:0]; b2 = bv[3:0]; end
    endcase
  endtask

  // Reference: plain integer comparison, latency from the highest differing bit.
  function automatic logic [2:0] model_res(input int w, input logic [7:0] av, input logic [7:0] bv);
    int x, y;
    if (w == 1) begin x = int'($signed(av)); y = int'($signed(bv)); end
    else if (w == 2) begin x = int'(av[3:0]); y = int'(bv[3:0]); end
    else begin x = int'(av); y = int'(bv); end
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input int w, input logic [7:0] av, input logic [7:0] bv);
    int W = wid(w);
    logic [7:0] d = av ^ bv;
    for (int p = W - 1; p >= 0; p--)
      if (d[p]) return W - p;
    return W;
  endfunction

  // One full compare: start for one cycle, scramble a/b after E0, count busy cycles until done.
  task automatic do_cmp(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] exp_res, input int exp_lat, input string tag);
    int  nb = 0;
    bit  seen = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, ~av, ~bv);
    check({tag, "_clr"}, {29'd0, res(w)}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (done[w]) begin seen = 1; break; end
      if (busy[w]) nb++;
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    check({tag, "_lat"}, nb, exp_lat);
    check({tag, "_res"}, {29'd0, res(w)}, {29'd0, exp_res});
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, done[w], busy[w]}, 32'd0);
    check({tag, "_hold"}, {29'd0, res(w)}, {29'd0, exp_res});
  endtask

  initial begin
    int ndone, prev;
    logic [2:0] rseen;
    logic [7:0] ra, rb;
    int rw;

    tbl[0] = '{0, 8'h80, 8'h7F, 3'b100, 1};
    tbl[1] = '{1, 8'h80, 8'h7F, 3'b001, 1};
    tbl[2] = '{1, 8'hFF, 8'hFE, 3'b100, 8};
    tbl[3] = '{0, 8'hA5, 8'hA5, 3'b010, 8};
    tbl[4] = '{0, 8'h01, 8'h00, 3'b100, 8};
    tbl[5] = '{2, 8'h03, 8'h05, 3'b001, 2};
    tbl[6] = '{1, 8'h7F, 8'h80, 3'b100, 1};
    tbl[7] = '{1, 8'h00, 8'hFF, 3'b100, 1};
    tbl[8] = '{0, 8'hFF, 8'hFF, 3'b010, 8};
    tbl[9] = '{1, 8'h80, 8'h80, 3'b010, 8};

    reset = 1'b1;
    st = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, done, gt, eq, lt}, 32'd0);
    reset = 1'b0;

    foreach (tbl[i])
      do_cmp(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, $sformatf("vec%0d", i));

    // start pulsed mid-compare with new operands must be ignored
    @(negedge clk);
    drive(0, 1'b1, 8'hA5, 8'hA5);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk); drive(0, 1'b1, 8'h00, 8'hFF);
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00);
    ndone = 0; rseen = '0;
    for (int c = 0; c < 14; c++) begin
      if (done[0]) begin ndone++; rseen = res(0); end
      @(negedge clk);
    end
    check("ign_ndone", ndone, 1);
    check("ign_res", {29'd0, rseen}, 32'd2);
    check("ign_hold", {29'd0, res(0)}, 32'd2);

    // async reset at E0+3 of an 8-cycle compare
    do_cmp(1, 8'h80, 8'h7F, 3'b001, 1, "pre_rst");
    @(negedge clk);
    drive(0, 1'b1, 8'hA5, 8'hA5);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_u8", {busy[0], done[0], gt[0], eq[0], lt[0]}, 32'd0);
    check("rst_s8_res", {29'd0, res(1)}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done[0] || busy[0]) ndone++;
    end
    check("rst_quiet", ndone, 0);
    check("rst_res", {29'd0, res(0)}, 32'd0);
    do_cmp(0, 8'h80, 8'h7F, 3'b100, 1, "post_rst");

    // start held high: back-to-back compares, period = 2 busy + done + idle
    @(negedge clk);
    drive(2, 1'b1, 8'h03, 8'h05);
    ndone = 0; prev = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done[2]) begin
        check($sformatf("held_lt%0d", ndone), {29'd0, res(2)}, 32'd1);
        if (prev >= 0) check($sformatf("held_gap%0d", ndone), c - prev, 4);
        prev = c;
        ndone++;
      end
    end
    check("held_ndone", ndone, 10);
    drive(2, 1'b0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);

    // random operands against the model
    for (int i = 0; i < 60; i++) begin
      rw = int'($urandom_range(0, 2));
      ra = 8'($urandom);
      rb = ((i % 5) == 0) ? ra : 8'($urandom);
      do_cmp(rw, ra, rb, model_res(rw, ra, rb), model_lat(rw, ra, rb), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
